// File: rtl/trap_pkg.sv
// Shared types for the simulation-end controller: trap causes, ebreak encoding, FSM states.
package trap_pkg;

    typedef enum logic [1:0] {
        TRAP_GOOD    = 2'd0,
        TRAP_BAD     = 2'd1,
        TRAP_STUCK   = 2'd2,
        TRAP_TIMEOUT = 2'd3
    } trap_code_t;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/trap_watchdog.sv
// Hang and timeout detection for trap_ctrl: stall/same-PC run lengths and the cycle-budget compare.
// Hits are combinational for the current cycle; counters only advance while run is high.
module trap_watchdog
    import trap_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int STUCK_LIMIT    = 64,
    parameter int CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      last_pc,
    input  logic             last_vld,
    input  logic [CNT_W-1:0] cycle_cnt,
    output logic             stuck_hit,
    output logic             timeout_hit
);

    localparam int               SW      = $clog2(STUCK_LIMIT + 1);
    localparam logic [SW-1:0]    LIMIT   = SW'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0] stall_cnt, stall_nxt;
    logic [SW-1:0] same_pc_cnt, same_pc_nxt;

    // The hit compares the updated count, so the limit-th offending cycle is the trigger cycle.
    always_comb begin
        stall_nxt   = stall_cnt;
        same_pc_nxt = same_pc_cnt;
        if (retire_valid) begin
            stall_nxt = '0;
            if (last_vld && (retire_pc == last_pc))
                same_pc_nxt = (same_pc_cnt == '1) ? same_pc_cnt : same_pc_cnt + 1'b1;
            else
                same_pc_nxt = SW'(1);
        end else begin
            stall_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    assign stuck_hit   = run && ((stall_nxt >= LIMIT) || (same_pc_nxt >= LIMIT));
    assign timeout_hit = run && (TIMEOUT_CYCLES != 0) && (cycle_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt   <= '0;
            same_pc_cnt <= '0;
        end else if (run) begin
            stall_cnt   <= stall_nxt;
            same_pc_cnt <= same_pc_nxt;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Simulation-end controller: detects ebreak/hang/timeout, freezes the core, drains, then presents a stable trap record.
// Record and freeze appear one cycle after the trigger; done follows DRAIN_CYCLES later and holds until reset.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int STUCK_LIMIT    = 64,
    parameter int DRAIN_CYCLES   = 4,
    parameter int CNT_W          = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    input  logic [31:0]      retire_inst,
    input  logic [31:0]      retire_a0,
    input  logic             overflow,
    output logic             freeze,
    output logic             done,
    output logic [1:0]       trap_code,
    output logic [31:0]      trap_pc,
    output logic [31:0]      trap_inst,
    output logic [31:0]      exit_code,
    output logic             overflow_seen,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    ctrl_state_t   state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic [31:0]   last_pc, last_inst;
    logic          last_vld;
    logic          run, ebreak_hit, stuck_hit, timeout_hit, trig;
    trap_code_t    code_nxt;
    logic [31:0]   pc_nxt, inst_nxt, exit_nxt;

    assign run        = (state == ST_RUN);
    assign ebreak_hit = retire_valid && (retire_inst == EBREAK_INST);

    trap_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STUCK_LIMIT    (STUCK_LIMIT),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .last_pc      (last_pc),
        .last_vld     (last_vld),
        .cycle_cnt    (cycle_cnt),
        .stuck_hit    (stuck_hit),
        .timeout_hit  (timeout_hit)
    );

    // last_pc/last_inst stay 0 until the first retire, which gives the "nothing retired" record for free.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        trig      = 1'b0;
        code_nxt  = TRAP_GOOD;
        pc_nxt    = retire_valid ? retire_pc   : last_pc;
        inst_nxt  = retire_valid ? retire_inst : last_inst;
        exit_nxt  = '0;
        case (state)
            ST_RUN: begin
                if (ebreak_hit) begin
                    trig     = 1'b1;
                    code_nxt = (retire_a0 == '0) ? TRAP_GOOD : TRAP_BAD;
                    exit_nxt = retire_a0;
                end else if (stuck_hit) begin
                    trig     = 1'b1;
                    code_nxt = TRAP_STUCK;
                end else if (timeout_hit) begin
                    trig     = 1'b1;
                    code_nxt = TRAP_TIMEOUT;
                end
                if (trig) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0)
                    state_nxt = ST_DONE;
                else
                    drain_nxt = drain_cnt - 1'b1;
            end
            ST_DONE: ;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            freeze    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            freeze    <= (state_nxt != ST_RUN);
            done      <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            trap_code <= '0;
            trap_pc   <= '0;
            trap_inst <= '0;
            exit_code <= '0;
        end else if (trig) begin
            trap_code <= code_nxt;
            trap_pc   <= pc_nxt;
            trap_inst <= inst_nxt;
            exit_code <= exit_nxt;
        end
    end

    // The trigger cycle is still a RUN cycle, so it is counted like any other.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt     <= '0;
            instret_cnt   <= '0;
            overflow_seen <= 1'b0;
            last_pc       <= '0;
            last_inst     <= '0;
            last_vld      <= 1'b0;
        end else if (run) begin
            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (retire_valid) begin
                if (instret_cnt != '1)
                    instret_cnt <= instret_cnt + 1'b1;
                last_pc   <= retire_pc;
                last_inst <= retire_inst;
                last_vld  <= 1'b1;
                if (overflow)
                    overflow_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected trap records are queued when the trigger is driven
// and checked against the DUT at freeze and again at done.
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int TO = 100;
    localparam int SL = 8;
    localparam int DC = 4;
    localparam int CW = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JAL = 32'h0000_006F;

    logic          clk, rst;
    logic          retire_valid, overflow;
    logic [31:0]   retire_pc, retire_inst, retire_a0;
    logic          freeze, done, overflow_seen;
    logic [1:0]    trap_code;
    logic [31:0]   trap_pc, trap_inst, exit_code;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
        logic [63:0] cyc;
        logic [63:0] ins;
        logic        ovf;
    } rec_t;

    rec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    trap_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .STUCK_LIMIT    (SL),
        .DRAIN_CYCLES   (DC),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .retire_inst   (retire_inst),
        .retire_a0     (retire_a0),
        .overflow      (overflow),
        .freeze        (freeze),
        .done          (done),
        .trap_code     (trap_code),
        .trap_pc       (trap_pc),
        .trap_inst     (trap_inst),
        .exit_code     (exit_code),
        .overflow_seen (overflow_seen),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [1:0] c, input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] exc, input int cyc, input int ins, input logic ovf);
        rec_t r;
        r.code = c; r.pc = pc; r.inst = inst; r.exc = exc;
        r.cyc = 64'(cyc); r.ins = 64'(ins); r.ovf = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] a0, input logic ovf);
        retire_valid = v;
        retire_pc    = pc;
        retire_inst  = inst;
        retire_a0    = a0;
        overflow     = ovf;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Holds rst low for two cycles, checking every output is cleared after the first.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        idle();
        tick();
        chk({tag, ".freeze"},   freeze,        0);
        chk({tag, ".done"},     done,          0);
        chk({tag, ".code"},     trap_code,     0);
        chk({tag, ".pc"},       trap_pc,       0);
        chk({tag, ".inst"},     trap_inst,     0);
        chk({tag, ".exit"},     exit_code,     0);
        chk({tag, ".ovf"},      overflow_seen, 0);
        chk({tag, ".cycle"},    cycle_cnt,     0);
        chk({tag, ".instret"},  instret_cnt,   0);
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_rec(input string tag, input rec_t e);
        chk({tag, ".code"},    trap_code,     e.code);
        chk({tag, ".pc"},      trap_pc,       e.pc);
        chk({tag, ".inst"},    trap_inst,     e.inst);
        chk({tag, ".exit"},    exit_code,     e.exc);
        chk({tag, ".cycle"},   cycle_cnt,     e.cyc);
        chk({tag, ".instret"}, instret_cnt,   e.ins);
        chk({tag, ".ovf"},     overflow_seen, e.ovf);
    endtask

    // Called right after the trigger cycle; keeps a bogus retire stream going during drain.
    task automatic expect_trap(input string tag);
        int   k;
        rec_t e;
        chk({tag, ".freeze_t1"}, freeze, 1);
        chk({tag, ".done_t1"},   done,   0);
        chk_rec({tag, ".t1"}, sb[0]);
        drive(1'b1, 32'h9000_0000, EBREAK_INST, 32'h7, 1'b1);
        k = 1;
        while (done !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        idle();
        chk({tag, ".done_latency"}, 64'(k), 64'(DC + 1));
        chk({tag, ".freeze_held"}, freeze, 1);
        e = sb.pop_front();
        chk_rec({tag, ".done"}, e);
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Good ebreak after 10 retires; one retire carries the overflow flag.
        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(4 * i), NOP, 32'h5, i == 3);
            tick();
        end
        chk("good.pre_freeze", freeze, 0);
        sb.push_back(mk(TRAP_GOOD, 32'h8000_0028, EBREAK_INST, 32'h0, 11, 11, 1'b1));
        drive(1'b1, 32'h8000_0028, EBREAK_INST, 32'h0, 1'b0);
        tick();
        expect_trap("good");

        // Bad ebreak, a0 = 1.
        do_reset("rst1");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0100 + 32'(4 * i), NOP, 32'hAA, 1'b0);
            tick();
        end
        sb.push_back(mk(TRAP_BAD, 32'h8000_010C, EBREAK_INST, 32'h1, 4, 4, 1'b0));
        drive(1'b1, 32'h8000_010C, EBREAK_INST, 32'h1, 1'b0);
        tick();
        expect_trap("bad");

        // No retires at all: stall hang in cycle 8, empty record.
        do_reset("rst2");
        for (int i = 0; i < SL - 1; i++) tick();
        chk("stall.pre_freeze", freeze, 0);
        sb.push_back(mk(TRAP_STUCK, 32'h0, 32'h0, 32'h0, SL, 0, 1'b0));
        tick();
        expect_trap("stall");

        // One retire elsewhere, then jal x0,0 spinning: hang on the 8th same-PC retire.
        do_reset("rst3");
        drive(1'b1, 32'h8000_0000, NOP, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < SL; i++) begin
            if (i == SL - 1) begin
                chk("spin.pre_freeze", freeze, 0);
                sb.push_back(mk(TRAP_STUCK, 32'h8000_0010, JAL, 32'h0, SL + 1, SL + 1, 1'b0));
            end
            drive(1'b1, 32'h8000_0010, JAL, 32'h3, 1'b0);
            tick();
        end
        expect_trap("spin");

        // Ebreak in the same cycle the watchdog expires: ebreak wins.
        do_reset("rst4");
        for (int i = 0; i < TO - 1; i++) begin
            drive(1'b1, 32'h8000_1000 + 32'(4 * i), NOP, 32'h9, 1'b0);
            tick();
        end
        chk("ebto.pre_freeze", freeze, 0);
        sb.push_back(mk(TRAP_GOOD, 32'h8000_1000 + 32'(4 * (TO - 1)), EBREAK_INST, 32'h0, TO, TO, 1'b0));
        drive(1'b1, 32'h8000_1000 + 32'(4 * (TO - 1)), EBREAK_INST, 32'h0, 1'b0);
        tick();
        expect_trap("ebto");

        // Same run without the ebreak: timeout in RUN cycle 100.
        do_reset("rst5");
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) begin
                chk("tmo.pre_freeze", freeze, 0);
                sb.push_back(mk(TRAP_TIMEOUT, 32'h8000_1000 + 32'(4 * i), NOP, 32'h0, TO, TO, 1'b0));
            end
            drive(1'b1, 32'h8000_1000 + 32'(4 * i), NOP, 32'h9, 1'b0);
            tick();
        end
        expect_trap("tmo");

        // Reset in the middle of drain, then a clean good run.
        do_reset("rst6");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h8000_0200 + 32'(4 * i), NOP, 32'h1, 1'b0);
            tick();
        end
        sb.push_back(mk(TRAP_GOOD, 32'h8000_0208, EBREAK_INST, 32'h0, 3, 3, 1'b0));
        drive(1'b1, 32'h8000_0208, EBREAK_INST, 32'h0, 1'b0);
        tick();
        idle();
        chk("mid.freeze_t1", freeze, 1);
        chk_rec("mid.t1", sb[0]);
        void'(sb.pop_front());
        tick();
        do_reset("mid_rst");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h8000_0300 + 32'(4 * i), NOP, 32'h2, 1'b0);
            tick();
        end
        sb.push_back(mk(TRAP_GOOD, 32'h8000_0308, EBREAK_INST, 32'h0, 3, 3, 1'b0));
        drive(1'b1, 32'h8000_0308, EBREAK_INST, 32'h0, 1'b0);
        tick();
        expect_trap("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
